// File: rtl/nabp_filtered_ram_fill_sequencer_if.sv
// Sequencer <-> filter / filtered-RAM swap control signal bundle.
interface nabp_filtered_ram_fill_sequencer_if #(
  parameter int unsigned kAngleLength        = 9,
  parameter int unsigned kSLength            = 9,
  parameter int unsigned kFilteredDataLength = 16
);
  logic [kSLength-1:0]            hs_s_val;
  logic                           filter_enable;
  logic                           filter_clear;
  logic [kFilteredDataLength-1:0] filter_out;
  logic                           wr_en;
  logic [kSLength-1:0]            wr_addr;
  logic [kFilteredDataLength-1:0] wr_data;
  logic [kAngleLength-1:0]        hs_angle;
  logic                           bank_ready;
  logic                           bank_ack;
  logic                           hs_has_next_angle;

  // Sequencer side.
  modport master (
    output hs_s_val, filter_enable, filter_clear, wr_en, wr_addr, wr_data, hs_angle,
           bank_ready, hs_has_next_angle,
    input  filter_out, bank_ack
  );

  // Filter / swap-control side.
  modport slave (
    input  hs_s_val, filter_enable, filter_clear, wr_en, wr_addr, wr_data, hs_angle,
           bank_ready, hs_has_next_angle,
    output filter_out, bank_ack
  );
endinterface

// File: rtl/nabp_filtered_ram_fill_sequencer.sv
// Per-angle filtered line fill: clear filter, sweep sinogram line, write the delayed
// filtered stream into the free bank, then offer the bank and step the angle.
module nabp_filtered_ram_fill_sequencer #(
  parameter int unsigned kAngleLength        = 9,
  parameter int unsigned kSLength            = 9,
  parameter int unsigned kFilteredDataLength = 16,
  parameter int unsigned kProjectionLineSize = 256,
  parameter int unsigned kFilterDelay        = 16,
  parameter int unsigned kAngleStep          = 1,
  parameter int unsigned kAngleLimit         = 180
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  nabp_filtered_ram_fill_sequencer_if.master bus_io,
  output logic busy_o,
  output logic done_o
);

  localparam logic [kSLength-1:0]   LastAddr    = kSLength'(kProjectionLineSize - 1);
  localparam logic [kAngleLength:0] AngleStepW  = (kAngleLength + 1)'(kAngleStep);
  localparam logic [kAngleLength:0] AngleLimitW = (kAngleLength + 1)'(kAngleLimit);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSweep,
    StDrain,
    StWait,
    StFinished
  } state_e;

  state_e                  state_q, state_d;
  logic [kSLength-1:0]     rd_cnt_q, rd_cnt_d;
  logic [kSLength-1:0]     wr_cnt_q, wr_cnt_d;
  logic [kAngleLength-1:0] angle_q, angle_d;
  // Bit k set means an address issued k+1 cycles ago; the top bit lines up with filter_out.
  logic [kFilterDelay:0]   vld_q, vld_d;
  logic                    issue;
  logic                    write;
  logic [kAngleLength:0]   angle_next;
  logic                    has_next;

  assign write      = vld_q[kFilterDelay];
  // One extra bit so the limit compare cannot wrap.
  assign angle_next = {1'b0, angle_q} + AngleStepW;
  assign has_next   = (angle_next < AngleLimitW);

  // State, counters, angle and issue-tag pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      angle_q  <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      angle_q  <= angle_d;
      vld_q    <= vld_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    angle_d  = angle_q;
    issue    = 1'b0;

    // Write address advances on each write and parks on the last address of the line.
    if (write && (wr_cnt_q != LastAddr)) begin
      wr_cnt_d = wr_cnt_q + kSLength'(1);
    end

    unique case (state_q)
      StIdle, StFinished: begin
        if (start_i) begin
          state_d = StClear;
          angle_d = '0;
        end
      end
      StClear: begin
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        state_d  = StSweep;
      end
      StSweep: begin
        issue = 1'b1;
        if (rd_cnt_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          rd_cnt_d = rd_cnt_q + kSLength'(1);
        end
      end
      StDrain: begin
        if (write && (wr_cnt_q == LastAddr)) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus_io.bank_ack) begin
          if (has_next) begin
            angle_d = angle_next[kAngleLength-1:0];
            state_d = StClear;
          end else begin
            state_d = StFinished;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    vld_d = {vld_q[kFilterDelay-1:0], issue};
  end

  // Outputs decode from registered state only (wr_data passes the filter through, gated).
  always_comb begin
    bus_io.hs_s_val          = rd_cnt_q;
    bus_io.filter_enable     = (state_q == StSweep) || (state_q == StDrain);
    bus_io.filter_clear      = (state_q == StClear);
    bus_io.wr_en             = write;
    bus_io.wr_addr           = wr_cnt_q;
    bus_io.wr_data           = write ? bus_io.filter_out : '0;
    bus_io.hs_angle          = angle_q;
    bus_io.bank_ready        = (state_q == StWait);
    busy_o                   = (state_q != StIdle) && (state_q != StFinished);
    bus_io.hs_has_next_angle = busy_o && has_next;
    done_o                   = (state_q == StFinished);
  end

endmodule

// File: tb/tb_nabp_filtered_ram_fill_sequencer.sv
// Bench: two sequencers (limit 180 and limit 170) sharing clock and reset, a fake
// RAM+filter that returns a salted hash of the issued address 1+D cycles later, and
// a cycle-accurate expectation of each line derived from the line timing rules.
module tb_nabp_filtered_ram_fill_sequencer;
  localparam int N       = 8;
  localparam int D       = 2;
  localparam int STEP    = 20;
  localparam int LIMIT_A = 180;
  localparam int LIMIT_B = 170;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_r = 1'b0;
  logic ack_r = 1'b0;
  logic sel = 1'b0;           // 0: drive/observe DUT A, 1: DUT B
  logic [7:0] salt = 8'h00;
  logic busy_a, done_a, busy_b, done_b;
  logic start_a, start_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nabp_filtered_ram_fill_sequencer_if #(.kAngleLength(9), .kSLength(9),
    .kFilteredDataLength(16)) bus_a ();
  nabp_filtered_ram_fill_sequencer_if #(.kAngleLength(9), .kSLength(9),
    .kFilteredDataLength(16)) bus_b ();

  nabp_filtered_ram_fill_sequencer #(
    .kAngleLength(9), .kSLength(9), .kFilteredDataLength(16), .kProjectionLineSize(N),
    .kFilterDelay(D), .kAngleStep(STEP), .kAngleLimit(LIMIT_A)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .bus_io(bus_a.master),
    .busy_o(busy_a), .done_o(done_a)
  );

  nabp_filtered_ram_fill_sequencer #(
    .kAngleLength(9), .kSLength(9), .kFilteredDataLength(16), .kProjectionLineSize(N),
    .kFilterDelay(D), .kAngleStep(STEP), .kAngleLimit(LIMIT_B)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .bus_io(bus_b.master),
    .busy_o(busy_b), .done_o(done_b)
  );

  function automatic logic [15:0] hash(input logic [8:0] a, input logic [7:0] s);
    return {s, a[7:0]} ^ 16'hA5C3;
  endfunction

  // Fake sinogram RAM (1 cycle) + filter (D cycles): output tracks the address 1+D back.
  logic [8:0] sreg_a [D+1];
  logic [8:0] sreg_b [D+1];
  always @(posedge clk) begin
    sreg_a[0] <= bus_a.hs_s_val;
    sreg_b[0] <= bus_b.hs_s_val;
    for (int i = 1; i <= D; i++) begin
      sreg_a[i] <= sreg_a[i-1];
      sreg_b[i] <= sreg_b[i-1];
    end
  end
  assign bus_a.filter_out = hash(sreg_a[D], salt);
  assign bus_b.filter_out = hash(sreg_b[D], salt);

  assign start_a        = start_r & ~sel;
  assign start_b        = start_r & sel;
  assign bus_a.bank_ack = ack_r & ~sel;
  assign bus_b.bank_ack = ack_r & sel;

  // Observation of the selected DUT.
  logic [8:0]  m_sval, m_wr_addr, m_angle;
  logic [15:0] m_wr_data;
  logic        m_fen, m_fclr, m_wr_en, m_ready, m_next, m_busy, m_done;
  assign m_sval    = sel ? bus_b.hs_s_val          : bus_a.hs_s_val;
  assign m_wr_addr = sel ? bus_b.wr_addr           : bus_a.wr_addr;
  assign m_angle   = sel ? bus_b.hs_angle          : bus_a.hs_angle;
  assign m_wr_data = sel ? bus_b.wr_data           : bus_a.wr_data;
  assign m_fen     = sel ? bus_b.filter_enable     : bus_a.filter_enable;
  assign m_fclr    = sel ? bus_b.filter_clear      : bus_a.filter_clear;
  assign m_wr_en   = sel ? bus_b.wr_en             : bus_a.wr_en;
  assign m_ready   = sel ? bus_b.bank_ready        : bus_a.bank_ready;
  assign m_next    = sel ? bus_b.hs_has_next_angle : bus_a.hs_has_next_angle;
  assign m_busy    = sel ? busy_b                  : busy_a;
  assign m_done    = sel ? done_b                  : done_a;

  typedef struct {
    int         ack_dly;
    bit         spurious;
    logic [8:0] angle;
    bit         has_next;
  } line_vec_t;

  line_vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse start; returns at the negedge of the CLEAR cycle (c0).
  task automatic start_sweep();
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
  endtask

  // Entered at the negedge of c0; returns at the negedge of the cycle after the ack.
  task automatic do_line(input logic [8:0] ang, input bit has_next, input int ack_dly,
                         input bit spurious);
    salt = 8'($urandom);
    chk("clear_c0", 32'(m_fclr), 32'(1));
    chk("angle_c0", 32'(m_angle), 32'(ang));
    chk("busy_c0", 32'(m_busy), 32'(1));
    chk("done_c0", 32'(m_done), 32'(0));
    chk("ready_c0", 32'(m_ready), 32'(0));
    for (int t = 1; t <= N + D + 1; t++) begin
      @(negedge clk);
      chk("sval", 32'(m_sval), (t <= N) ? 32'(t - 1) : 32'(N - 1));
      chk("fen_line", 32'(m_fen), 32'(1));
      chk("fclr_line", 32'(m_fclr), 32'(0));
      chk("wr_en_line", 32'(m_wr_en), 32'(t >= 2 + D));
      if (t >= 2 + D) begin
        chk("wr_addr", 32'(m_wr_addr), 32'(t - 2 - D));
        chk("wr_data", 32'(m_wr_data), 32'(hash(9'(t - 2 - D), salt)));
      end
      chk("ready_line", 32'(m_ready), 32'(0));
      chk("angle_line", 32'(m_angle), 32'(ang));
      if (spurious && t == 3) begin
        start_r = 1'b1;
        ack_r   = 1'b1;
      end else begin
        start_r = 1'b0;
        ack_r   = 1'b0;
      end
    end
    for (int w = 0; w <= ack_dly; w++) begin
      @(negedge clk);
      chk("ready_wait", 32'(m_ready), 32'(1));
      chk("fen_wait", 32'(m_fen), 32'(0));
      chk("wr_en_wait", 32'(m_wr_en), 32'(0));
      chk("angle_wait", 32'(m_angle), 32'(ang));
      chk("has_next", 32'(m_next), 32'(has_next));
      chk("busy_wait", 32'(m_busy), 32'(1));
      if (w == ack_dly) ack_r = 1'b1;
    end
    @(negedge clk);
    ack_r = 1'b0;
  endtask

  task automatic chk_finished(input string tag);
    chk({tag, "_done"}, 32'(m_done), 32'(1));
    chk({tag, "_busy"}, 32'(m_busy), 32'(0));
    chk({tag, "_ready"}, 32'(m_ready), 32'(0));
    chk({tag, "_fen"}, 32'(m_fen), 32'(0));
    chk({tag, "_wr_en"}, 32'(m_wr_en), 32'(0));
  endtask

  initial begin
    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sval", 32'(m_sval), 32'(0));
    chk("rst_fen", 32'(m_fen), 32'(0));
    chk("rst_fclr", 32'(m_fclr), 32'(0));
    chk("rst_wr_en", 32'(m_wr_en), 32'(0));
    chk("rst_angle", 32'(m_angle), 32'(0));
    chk("rst_ready", 32'(m_ready), 32'(0));
    chk("rst_next", 32'(m_next), 32'(0));
    chk("rst_busy", 32'(m_busy), 32'(0));
    chk("rst_done", 32'(m_done), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-SWEEP.
    start_sweep();
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(m_busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_sval", 32'(m_sval), 32'(0));
    chk("midrst_fen", 32'(m_fen), 32'(0));
    chk("midrst_wr_en", 32'(m_wr_en), 32'(0));
    chk("midrst_wr_addr", 32'(m_wr_addr), 32'(0));
    chk("midrst_wr_data", 32'(m_wr_data), 32'(0));
    chk("midrst_busy", 32'(m_busy), 32'(0));
    chk("midrst_angle", 32'(m_angle), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("postrst_wr_en", 32'(m_wr_en), 32'(0));
      chk("postrst_busy", 32'(m_busy), 32'(0));
    end

    // Full sweep on DUT A, table-driven: angle k*STEP while below the limit.
    for (int k = 0; k < 9; k++) begin
      tbl[k].angle    = 9'(k * STEP);
      tbl[k].has_next = ((k + 1) * STEP < LIMIT_A);
      tbl[k].ack_dly  = int'($urandom_range(0, 5));
      tbl[k].spurious = 1'($urandom_range(0, 1));
    end
    tbl[1].spurious = 1'b1;
    start_sweep();
    for (int k = 0; k < 9; k++) begin
      do_line(tbl[k].angle, tbl[k].has_next, tbl[k].ack_dly, tbl[k].spurious);
    end
    chk_finished("fin_a");
    chk("fin_a_angle", 32'(m_angle), 32'(160));

    // ack in FINISHED is ignored, done holds.
    ack_r = 1'b1;
    @(negedge clk);
    ack_r = 1'b0;
    repeat (3) @(negedge clk);
    chk_finished("fin_a_hold");

    // Restart, then stall the ack for 50 cycles.
    start_sweep();
    do_line(9'd0, 1'b1, 50, 1'b0);
    chk("stall_next_clear", 32'(m_fclr), 32'(1));
    chk("stall_next_angle", 32'(m_angle), 32'(STEP));

    // DUT B: limit not a multiple of the step.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1;
    start_sweep();
    for (int k = 0; k * STEP < LIMIT_B; k++) begin
      do_line(9'(k * STEP), ((k + 1) * STEP < LIMIT_B), 0, 1'b0);
    end
    chk_finished("fin_b");
    chk("fin_b_angle", 32'(m_angle), 32'(160));
    start_sweep();
    chk("restart_b_done", 32'(m_done), 32'(0));
    chk("restart_b_angle", 32'(m_angle), 32'(0));
    chk("restart_b_clear", 32'(m_fclr), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
